i2c_slv_sched: RTL and testbench

//  Word-level scheduler on the user side of the I2C slave PHY. Read path: arbitrates two 32-bit

---
 rtl/i2c_slv_sched_if.sv | 42 ++++
 rtl/i2c_slv_sched.sv | 126 ++++++++++++
 tb/tb_i2c_slv_sched.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slv_sched_if.sv
// i2c_slv_sched_if: PHY, read-source and command-sink signals of the I2C slave word scheduler
interface i2c_slv_sched_if #(
   parameter int CNT_W = 16,
   parameter int LEN_W = 8
);
   logic             phy_push;
   logic [31:0]      phy_dout;
   logic             phy_full;
   logic             phy_pop;
   logic [31:0]      phy_din;
   logic             phy_empty;
   logic             phy_wstop;
   logic             phy_rstop;
   logic             phy_rerr;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [31:0]      rsp_data;
   logic             sts_valid;
   logic             sts_ready;
   logic [31:0]      sts_data;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [31:0]      cmd_data;
   logic             wr_done;
   logic [LEN_W-1:0] wr_len;
   logic             rd_done;
   logic             sts_drop;
   logic [CNT_W-1:0] rd_err_cnt;
   logic [CNT_W-1:0] wr_drop_cnt;
   modport slave (
      input  phy_push, phy_dout, phy_pop, phy_wstop, phy_rstop, phy_rerr,
      input  rsp_valid, rsp_data, sts_valid, sts_data, cmd_ready,
      output phy_full, phy_din, phy_empty, rsp_ready, sts_ready, cmd_valid, cmd_data,
      output wr_done, wr_len, rd_done, sts_drop, rd_err_cnt, wr_drop_cnt
   );
   modport master (
      output phy_push, phy_dout, phy_pop, phy_wstop, phy_rstop, phy_rerr,
      output rsp_valid, rsp_data, sts_valid, sts_data, cmd_ready,
      input  phy_full, phy_din, phy_empty, rsp_ready, sts_ready, cmd_valid, cmd_data,
      input  wr_done, wr_len, rd_done, sts_drop, rd_err_cnt, wr_drop_cnt
   );
endinterface

// File: rtl/i2c_slv_sched.sv
// i2c_slv_sched: arbitrates response/status words into the PHY read holding register with replay, and buffers PHY write words to the command sink
module i2c_slv_sched #(
   parameter int STAT_TTL = 1000,
   parameter int CNT_W    = 16,
   parameter int LEN_W    = 8
) (
   input logic clk,
   input logic rst,
   i2c_slv_sched_if.slave bus
);
   localparam logic [0:0] EMPTY = 1'b0;
   localparam logic [0:0] HOLD  = 1'b1;
   localparam int AW = $clog2(STAT_TTL);
   logic [0:0]       state;
   logic [31:0]      hold;
   logic [31:0]      replay;
   logic             src;
   logic             last_grant;
   logic             replay_vld;
   logic             replay_pend;
   logic [AW-1:0]    age;
   logic             rd_done;
   logic [CNT_W-1:0] rd_err_cnt;
   logic             cmd_vld_q;
   logic [31:0]      cmd_data;
   logic [LEN_W-1:0] wr_len_cnt;
   logic [LEN_W-1:0] wr_len;
   logic             wr_done;
   logic [CNT_W-1:0] wr_drop_cnt;
   logic             take_replay;
   logic             grant_rsp;
   logic             grant_sts;
   logic             pop_take;
   logic             expire;
   logic             cmd_valid;
   logic             accept;
   logic             drop;
   logic [LEN_W-1:0] len_next;
   // grant, expiry and write-acceptance decisions; no handshakes are offered while rst is high
   always_comb begin
      take_replay = !rst && state == EMPTY && replay_pend && replay_vld;
      grant_rsp   = !rst && state == EMPTY && !take_replay && bus.rsp_valid && (!bus.sts_valid || last_grant);
      grant_sts   = !rst && state == EMPTY && !take_replay && bus.sts_valid && (!bus.rsp_valid || !last_grant);
      pop_take    = state == HOLD && bus.phy_pop;
      expire      = !rst && state == HOLD && src && age == AW'(STAT_TTL - 1) && !bus.phy_pop;
      cmd_valid   = cmd_vld_q && !rst;
      accept      = bus.phy_push && (!cmd_valid || bus.cmd_ready);
      drop        = bus.phy_push && cmd_valid && !bus.cmd_ready;
      len_next    = (accept && !(&wr_len_cnt)) ? wr_len_cnt + LEN_W'(1) : wr_len_cnt;
   end
   assign bus.rsp_ready   = grant_rsp;
   assign bus.sts_ready   = grant_sts;
   assign bus.phy_din     = hold;
   assign bus.phy_empty   = state != HOLD;
   assign bus.sts_drop    = expire;
   assign bus.rd_done     = rd_done;
   assign bus.rd_err_cnt  = rd_err_cnt;
   assign bus.cmd_valid   = cmd_valid;
   assign bus.phy_full    = cmd_valid;
   assign bus.cmd_data    = cmd_data;
   assign bus.wr_done     = wr_done;
   assign bus.wr_len      = wr_len;
   assign bus.wr_drop_cnt = wr_drop_cnt;
   // read path: holding register fill/pop/expiry, replay bookkeeping and read error counting
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= EMPTY;
         hold        <= '0;
         replay      <= '0;
         src         <= 1'b0;
         last_grant  <= 1'b1;
         replay_vld  <= 1'b0;
         replay_pend <= 1'b0;
         age         <= '0;
         rd_done     <= 1'b0;
         rd_err_cnt  <= '0;
      end else begin
         if (take_replay) begin
            hold  <= replay;
            src   <= 1'b0;
            age   <= '0;
            state <= HOLD;
         end else if (grant_rsp || grant_sts) begin
            hold       <= grant_sts ? bus.sts_data : bus.rsp_data;
            src        <= grant_sts;
            last_grant <= grant_sts;
            age        <= '0;
            state      <= HOLD;
         end else if (pop_take || expire) begin
            state <= EMPTY;
         end else if (state == HOLD && src) begin
            age <= age + AW'(1);
         end
         if (take_replay)
            replay_pend <= 1'b0;
         else if (bus.phy_rerr && replay_vld && !bus.phy_pop)
            replay_pend <= 1'b1;
         if (pop_take) begin
            replay     <= hold;
            replay_vld <= 1'b1;
         end else if (bus.phy_rstop && !replay_pend) begin
            replay_vld <= 1'b0;
         end
         rd_done    <= bus.phy_rstop;
         rd_err_cnt <= (bus.phy_rerr && !(&rd_err_cnt)) ? rd_err_cnt + CNT_W'(1) : rd_err_cnt;
      end
   end
   // write path: one-word command buffer, per-transaction length and drop counting
   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_vld_q   <= 1'b0;
         cmd_data    <= '0;
         wr_len_cnt  <= '0;
         wr_len      <= '0;
         wr_done     <= 1'b0;
         wr_drop_cnt <= '0;
      end else begin
         cmd_vld_q   <= accept || (cmd_vld_q && !bus.cmd_ready);
         cmd_data    <= accept ? bus.phy_dout : cmd_data;
         wr_drop_cnt <= (drop && !(&wr_drop_cnt)) ? wr_drop_cnt + CNT_W'(1) : wr_drop_cnt;
         wr_done     <= bus.phy_wstop;
         wr_len      <= bus.phy_wstop ? len_next : wr_len;
         wr_len_cnt  <= bus.phy_wstop ? '0 : len_next;
      end
   end
endmodule

// File: tb/tb_i2c_slv_sched.sv
// tb_i2c_slv_sched: table-driven and scoreboard checks of the I2C slave word scheduler
module tb_i2c_slv_sched;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int vectors = 0;
   int miscompares = 0;
   logic [31:0] rd_q[$];
   logic [31:0] cmd_q[$];
   typedef struct {
      logic        rv;
      logic        sv;
      logic [31:0] exp;
      logic        exp_sts;
   } vec_t;
   vec_t tbl[9];
   i2c_slv_sched_if #(.CNT_W(16), .LEN_W(8)) bus();
   i2c_slv_sched #(.STAT_TTL(8), .CNT_W(16), .LEN_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   // read scoreboard: every accepted PHY pop must present the next expected word
   always @(negedge clk) begin
      if (!rst && bus.phy_pop && !bus.phy_empty) begin
         if (rd_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL rd_unexpected: got %h expected none", bus.phy_din);
         end else
            chk("rd_word", bus.phy_din, rd_q.pop_front());
      end
   end
   // command scoreboard: every sink handshake must carry the next expected word
   always @(negedge clk) begin
      if (!rst && bus.cmd_valid && bus.cmd_ready) begin
         if (cmd_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL cmd_unexpected: got %h expected none", bus.cmd_data);
         end else
            chk("cmd_word", bus.cmd_data, cmd_q.pop_front());
      end
   end
   initial begin
      tbl[0] = '{1'b1, 1'b1, 32'h1000_0000, 1'b0};
      tbl[1] = '{1'b1, 1'b1, 32'h2000_0001, 1'b1};
      tbl[2] = '{1'b1, 1'b1, 32'h1000_0002, 1'b0};
      tbl[3] = '{1'b1, 1'b1, 32'h2000_0003, 1'b1};
      tbl[4] = '{1'b1, 1'b0, 32'h1000_0004, 1'b0};
      tbl[5] = '{1'b1, 1'b0, 32'h1000_0005, 1'b0};
      tbl[6] = '{1'b1, 1'b1, 32'h2000_0006, 1'b1};
      tbl[7] = '{1'b0, 1'b1, 32'h2000_0007, 1'b1};
      tbl[8] = '{1'b1, 1'b1, 32'h1000_0008, 1'b0};
      {bus.phy_push, bus.phy_pop, bus.phy_wstop, bus.phy_rstop, bus.phy_rerr} = '0;
      {bus.rsp_valid, bus.sts_valid, bus.cmd_ready} = '0;
      {bus.phy_dout, bus.rsp_data, bus.sts_data} = '0;
      repeat (2) step();
      rst = 1'b0;
      chk("rst_empty", bus.phy_empty, 1);
      chk("rst_full", bus.phy_full, 0);
      chk("rst_cmd_valid", bus.cmd_valid, 0);
      chk("rst_din", bus.phy_din, 0);
      chk("rst_wr_done", bus.wr_done, 0);
      chk("rst_wr_len", bus.wr_len, 0);
      chk("rst_rd_done", bus.rd_done, 0);
      chk("rst_sts_drop", bus.sts_drop, 0);
      chk("rst_err_cnt", bus.rd_err_cnt, 0);
      chk("rst_drop_cnt", bus.wr_drop_cnt, 0);
      for (int i = 0; i < 9; i++) begin
         step();
         bus.rsp_valid = tbl[i].rv;
         bus.sts_valid = tbl[i].sv;
         bus.rsp_data = 32'h1000_0000 + i;
         bus.sts_data = 32'h2000_0000 + i;
         rd_q.push_back(tbl[i].exp);
         #1;
         chk("rsp_ready", bus.rsp_ready, !tbl[i].exp_sts);
         chk("sts_ready", bus.sts_ready, tbl[i].exp_sts);
         step();
         bus.rsp_valid = 1'b0;
         bus.sts_valid = 1'b0;
         chk("fill_empty", bus.phy_empty, 0);
         bus.phy_pop = 1'b1;
         step();
         bus.phy_pop = 1'b0;
         chk("pop_empty", bus.phy_empty, 1);
      end
      step();
      bus.sts_valid = 1'b1;
      bus.sts_data = 32'h5757_0000;
      step();
      bus.sts_valid = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         chk("sts_drop", bus.sts_drop, (k == 8) ? 1 : 0);
         chk("ttl_hold", bus.phy_empty, 0);
         step();
      end
      chk("ttl_empty", bus.phy_empty, 1);
      chk("ttl_drop_end", bus.sts_drop, 0);
      step();
      bus.rsp_valid = 1'b1;
      bus.rsp_data = 32'hA5A5_0001;
      rd_q.push_back(32'hA5A5_0001);
      step();
      bus.rsp_valid = 1'b0;
      bus.phy_pop = 1'b1;
      step();
      bus.phy_pop = 1'b0;
      bus.phy_rerr = 1'b1;
      step();
      bus.phy_rerr = 1'b0;
      bus.rsp_valid = 1'b1;
      bus.rsp_data = 32'h0000_0002;
      rd_q.push_back(32'hA5A5_0001);
      rd_q.push_back(32'h0000_0002);
      #1;
      chk("replay_preempt", bus.rsp_ready, 0);
      step();
      chk("replay_held", bus.phy_empty, 0);
      bus.phy_pop = 1'b1;
      step();
      bus.phy_pop = 1'b0;
      #1;
      chk("post_replay_grant", bus.rsp_ready, 1);
      step();
      bus.rsp_valid = 1'b0;
      bus.phy_pop = 1'b1;
      step();
      bus.phy_pop = 1'b0;
      bus.rsp_valid = 1'b1;
      bus.rsp_data = 32'h0000_0033;
      rd_q.push_back(32'h0000_0033);
      step();
      bus.rsp_valid = 1'b0;
      bus.phy_pop = 1'b1;
      bus.phy_rerr = 1'b1;
      step();
      bus.phy_pop = 1'b0;
      bus.phy_rerr = 1'b0;
      bus.rsp_valid = 1'b1;
      bus.rsp_data = 32'h0000_0044;
      rd_q.push_back(32'h0000_0044);
      #1;
      chk("pop_rerr_no_replay", bus.rsp_ready, 1);
      step();
      bus.rsp_valid = 1'b0;
      bus.phy_pop = 1'b1;
      step();
      bus.phy_pop = 1'b0;
      chk("err_cnt_2", bus.rd_err_cnt, 2);
      bus.phy_rstop = 1'b1;
      step();
      bus.phy_rstop = 1'b0;
      chk("rd_done", bus.rd_done, 1);
      step();
      chk("rd_done_pulse", bus.rd_done, 0);
      bus.cmd_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.phy_push = 1'b1;
         bus.phy_dout = 32'hC0DE_0000 + i;
         cmd_q.push_back(32'hC0DE_0000 + i);
         step();
      end
      bus.phy_push = 1'b0;
      bus.phy_wstop = 1'b1;
      step();
      bus.phy_wstop = 1'b0;
      chk("wr_done", bus.wr_done, 1);
      chk("wr_len_4", bus.wr_len, 4);
      step();
      chk("wr_done_pulse", bus.wr_done, 0);
      bus.cmd_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.phy_push = 1'b1;
         bus.phy_dout = 32'hD00D_0000 + i;
         if (i == 0) cmd_q.push_back(32'hD00D_0000);
         step();
      end
      bus.phy_push = 1'b0;
      chk("full_held", bus.phy_full, 1);
      chk("cmd_valid_held", bus.cmd_valid, 1);
      chk("drop_cnt_2", bus.wr_drop_cnt, 2);
      bus.cmd_ready = 1'b1;
      bus.phy_push = 1'b1;
      bus.phy_dout = 32'hD00D_0003;
      bus.phy_wstop = 1'b1;
      cmd_q.push_back(32'hD00D_0003);
      step();
      bus.phy_push = 1'b0;
      bus.phy_wstop = 1'b0;
      chk("wr_done_2", bus.wr_done, 1);
      chk("wr_len_2", bus.wr_len, 2);
      chk("drop_cnt_same", bus.wr_drop_cnt, 2);
      step();
      step();
      chk("full_clear", bus.phy_full, 0);
      bus.rsp_valid = 1'b1;
      bus.rsp_data = 32'h7777_0000;
      step();
      bus.rsp_valid = 1'b0;
      bus.phy_rerr = 1'b1;
      repeat (65539) step();
      bus.phy_rerr = 1'b0;
      chk("err_cnt_sat", bus.rd_err_cnt, 32'h0000_FFFF);
      chk("hold_undisturbed", bus.phy_din, 32'h7777_0000);
      chk("hold_still_full", bus.phy_empty, 0);
      bus.rsp_valid = 1'b1;
      rst = 1'b1;
      #1;
      chk("rst_no_ready", bus.rsp_ready, 0);
      step();
      rst = 1'b0;
      bus.rsp_valid = 1'b0;
      chk("rst_mid_empty", bus.phy_empty, 1);
      chk("rst_mid_err_cnt", bus.rd_err_cnt, 0);
      chk("rst_mid_drop_cnt", bus.wr_drop_cnt, 0);
      chk("rst_mid_cmd", bus.cmd_valid, 0);
      step();
      chk("rst_no_refill", bus.phy_empty, 1);
      chk("rd_q_drained", rd_q.size(), 0);
      chk("cmd_q_drained", cmd_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
